// File: rtl/frame_scan_controller.sv
// Frame scan controller: walks one frame of image memory in raster order,
// issuing a read every CYCLES_PER_PIXEL clocks, and carries a tag alongside
// each read so that pix_valid/line_end/frame_end line up with the returned data.
module frame_scan_controller #(
    parameter int WIDTH            = 720,
    parameter int HEIGHT           = 1280,
    parameter int CYCLES_PER_PIXEL = 3,
    parameter int LATENCY          = 4,
    parameter int ADDR_W           = 20,
    localparam int ROW_W           = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int COL_W           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              line_end,
    output logic              frame_end,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              busy,
    output logic              done
);

    localparam int PH_W = (CYCLES_PER_PIXEL > 1) ? $clog2(CYCLES_PER_PIXEL) : 1;
    localparam logic [PH_W-1:0]   LAST_PHASE = PH_W'(CYCLES_PER_PIXEL - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
    // Row value parked after the final pixel; clamped if HEIGHT itself does not fit.
    localparam logic [ROW_W-1:0]  ROW_END    =
        ROW_W'((HEIGHT < (1 << ROW_W)) ? HEIGHT : ((1 << ROW_W) - 1));

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [PH_W-1:0]     phase;
    logic [ADDR_W-1:0]   addr_cnt;
    logic                le_tag;
    logic                fe_tag;
    logic [2:0]          tag_pipe [LATENCY];

    logic                in_scan;
    logic                issue;
    logic                issue_last_col;
    logic                issue_last_pix;
    logic [PH_W-1:0]     cur_phase;
    logic [PH_W-1:0]     next_phase;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ROW_W-1:0]    cur_row;
    logic [COL_W-1:0]    cur_col;

    // The cycle that accepts start already issues pixel 0, so IDLE presents zeroed counters.
    always_comb begin
        cur_phase      = (state == IDLE) ? '0 : phase;
        cur_addr       = (state == IDLE) ? '0 : addr_cnt;
        cur_row        = (state == IDLE) ? '0 : row;
        cur_col        = (state == IDLE) ? '0 : col;
        in_scan        = (state == SCAN) || ((state == IDLE) && start);
        issue          = in_scan && (cur_phase == '0) && !pause;
        issue_last_col = (cur_col == LAST_COL);
        issue_last_pix = (cur_addr == LAST_ADDR);
        next_phase     = (cur_phase == LAST_PHASE) ? '0 : cur_phase + PH_W'(1);
    end

    // Data-side flags come straight off the end of the tag pipeline.
    assign pix_valid = tag_pipe[LATENCY-1][2];
    assign line_end  = tag_pipe[LATENCY-1][1];
    assign frame_end = tag_pipe[LATENCY-1][0];

    // Sequencing FSM, issue counters and the latency-matching tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            addr_cnt <= '0;
            row      <= '0;
            col      <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            le_tag   <= 1'b0;
            fe_tag   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= 3'b000;
            end
        end else begin
            tag_pipe[0] <= {rd_en, le_tag, fe_tag};
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            rd_en  <= issue;
            le_tag <= issue && issue_last_col;
            fe_tag <= issue && issue_last_pix;
            done   <= 1'b0;

            if (in_scan) begin
                if (state == IDLE) begin
                    state <= SCAN;
                    busy  <= 1'b1;
                end
                phase    <= pause ? cur_phase : next_phase;
                addr_cnt <= cur_addr;
                row      <= cur_row;
                col      <= cur_col;
                if (issue) begin
                    rd_addr <= cur_addr;
                    if (issue_last_pix) begin
                        state <= DRAIN;
                        row   <= ROW_END;
                        col   <= '0;
                    end else begin
                        addr_cnt <= cur_addr + ADDR_W'(1);
                        if (issue_last_col) begin
                            col <= '0;
                            row <= cur_row + ROW_W'(1);
                        end else begin
                            col <= cur_col + COL_W'(1);
                        end
                    end
                end
            end else begin
                case (state)
                    DRAIN: begin
                        if (pix_valid && frame_end) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_scan_controller.sv
// Directed testbench for frame_scan_controller on a 4x3 frame: one instance at
// three clocks per pixel with latency 2, one at one clock per pixel with latency 1.
module tb_frame_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic       start1;

    logic       rd_en, pix_valid, line_end, frame_end, busy, done;
    logic [3:0] rd_addr;
    logic [1:0] row, col;

    logic       rd_en1, pix_valid1, line_end1, frame_end1, busy1, done1;
    logic [3:0] rd_addr1;
    logic [1:0] row1, col1;

    int check_count = 0;
    int error_count = 0;

    frame_scan_controller #(
        .WIDTH(4), .HEIGHT(3), .CYCLES_PER_PIXEL(3), .LATENCY(2), .ADDR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .rd_en(rd_en), .rd_addr(rd_addr), .pix_valid(pix_valid),
        .line_end(line_end), .frame_end(frame_end), .row(row), .col(col),
        .busy(busy), .done(done)
    );

    frame_scan_controller #(
        .WIDTH(4), .HEIGHT(3), .CYCLES_PER_PIXEL(1), .LATENCY(1), .ADDR_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pause(1'b0),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .pix_valid(pix_valid1),
        .line_end(line_end1), .frame_end(frame_end1), .row(row1), .col(col1),
        .busy(busy1), .done(done1)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic p);
        rst   = r;
        start = s;
        pause = p;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Full unpaused frame, entered with the first SCAN cycle (T) already sampled.
    task automatic checkFrameTiming(input string pfx);
        for (int c = 0; c <= 36; c++) begin
            logic exp_rd, exp_pv;
            int   p;
            exp_rd = (c % 3 == 0) && (c / 3 < 12);
            p      = (c >= 2) ? (c - 2) / 3 : 0;
            exp_pv = (c >= 2) && ((c - 2) % 3 == 0) && (p < 12);
            checkOutput($sformatf("%s rd_en c%0d", pfx, c), rd_en, exp_rd);
            if (exp_rd)
                checkOutput($sformatf("%s rd_addr c%0d", pfx, c), rd_addr, c / 3);
            checkOutput($sformatf("%s pix_valid c%0d", pfx, c), pix_valid, exp_pv);
            checkOutput($sformatf("%s line_end c%0d", pfx, c), line_end,
                        exp_pv && (p % 4 == 3));
            checkOutput($sformatf("%s frame_end c%0d", pfx, c), frame_end,
                        exp_pv && (p == 11));
            checkOutput($sformatf("%s done c%0d", pfx, c), done, c == 36);
            checkOutput($sformatf("%s busy c%0d", pfx, c), busy, c <= 35);
            if (c == 35) begin
                checkOutput($sformatf("%s row_end", pfx), row, 3);
                checkOutput($sformatf("%s col_end", pfx), col, 0);
            end
            tick();
        end
    endtask

    initial begin
        int q[$];
        int exp_issue;
        int pix_seen;
        int done_cnt;
        int busy_seen;

        start1 = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] reset with start held high");
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst rd_en", rd_en, 0);
            checkOutput("rst rd_addr", rd_addr, 0);
            checkOutput("rst pix_valid", pix_valid, 0);
            checkOutput("rst line_end", line_end, 0);
            checkOutput("rst frame_end", frame_end, 0);
            checkOutput("rst row", row, 0);
            checkOutput("rst col", col, 0);
            checkOutput("rst busy", busy, 0);
            checkOutput("rst done", done, 0);
            checkOutput("rst busy1", busy1, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("idle busy", busy, 0);
        checkOutput("idle rd_en", rd_en, 0);

        $display("[TB] single frame");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkFrameTiming("frame");
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] pause during scan");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        exp_issue = 0;
        pix_seen  = 0;
        done_cnt  = 0;
        for (int c = 0; c < 80; c++) begin
            if (c == 6) checkOutput("pause rd_en c6", rd_en, 0);
            if (rd_en) begin
                checkOutput($sformatf("pause rd_addr #%0d", exp_issue), rd_addr, exp_issue);
                q.push_back(exp_issue);
                exp_issue++;
            end
            if (pix_valid) begin
                int a;
                a = (q.size() > 0) ? q.pop_front() : -1;
                checkOutput($sformatf("pause line_end a%0d", a), line_end, (a % 4) == 3);
                checkOutput($sformatf("pause frame_end a%0d", a), frame_end, a == 11);
                pix_seen++;
            end else begin
                if (line_end || frame_end)
                    checkOutput("pause tag without valid", {line_end, frame_end}, 0);
            end
            if (done) done_cnt++;
            if (c == 4) pause = 1'b1;
            if (c == 9) pause = 1'b0;
            tick();
        end
        checkOutput("pause issue count", exp_issue, 12);
        checkOutput("pause pixel count", pix_seen, 12);
        checkOutput("pause done count", done_cnt, 1);

        $display("[TB] start held high, back-to-back frames");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkFrameTiming("held");
        checkOutput("held c37 done", done, 0);
        checkOutput("held c37 busy", busy, 0);
        checkOutput("held c37 rd_en", rd_en, 0);
        tick();
        checkOutput("held c38 rd_en", rd_en, 1);
        checkOutput("held c38 rd_addr", rd_addr, 0);
        checkOutput("held c38 busy", busy, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 13; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst rd_en", rd_en, 0);
        checkOutput("midrst pix_valid", pix_valid, 0);
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst done", done, 0);
        busy_seen = 0;
        done_cnt  = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) done_cnt++;
            if (busy) busy_seen++;
        end
        checkOutput("midrst no done", done_cnt, 0);
        checkOutput("midrst stays idle", busy_seen, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkFrameTiming("restart");

        $display("[TB] one clock per pixel, latency 1");
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            checkOutput($sformatf("fast rd_en c%0d", c), rd_en1, c < 12);
            if (c < 12)
                checkOutput($sformatf("fast rd_addr c%0d", c), rd_addr1, c);
            checkOutput($sformatf("fast pix_valid c%0d", c), pix_valid1, (c >= 1) && (c <= 12));
            checkOutput($sformatf("fast line_end c%0d", c), line_end1,
                        (c >= 1) && (c <= 12) && ((c - 1) % 4 == 3));
            checkOutput($sformatf("fast frame_end c%0d", c), frame_end1, c == 12);
            checkOutput($sformatf("fast done c%0d", c), done1, c == 13);
            checkOutput($sformatf("fast busy c%0d", c), busy1, c <= 12);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
